// File: rtl/romulus_do_fifo.sv
// romulus_do_fifo: output FIFO between the LWC do_* port and the host.
// Ports: in_* from LWC, out_* to host, store_fwd mode, level/msg_pending status.
module romulus_do_fifo #(
  parameter int BUSW  = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BUSW-1:0] in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [BUSW-1:0] out_data,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            store_fwd,
  output logic [AW:0]     level,
  output logic [AW:0]     msg_pending
);

  localparam logic [AW:0] LFULL = (AW+1)'(DEPTH);

  logic [BUSW:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic [AW:0]     r_msg;
  logic            r_live;
  logic            r_hold;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [BUSW:0]   w_head;
  logic            w_inc;
  logic            w_dec;

  assign w_full  = (r_level == LFULL);
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // Ready is registered-state only; a pop cannot free space same cycle.
  assign in_ready = r_live & ~w_full;

  // Hold keeps a presented word valid even if store_fwd rises.
  always_comb begin
    out_valid = 1'b0;
    if (!w_empty) begin
      out_valid = ~store_fwd | r_hold | (r_msg != '0) | w_full;
    end
  end

  assign out_data = w_empty ? '0 : w_head[BUSW-1:0];
  assign out_last = w_empty ? 1'b0 : w_head[BUSW];

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;
  assign w_inc  = w_push & in_last;
  assign w_dec  = w_pop & w_head[BUSW];

  assign level       = r_level;
  assign msg_pending = r_msg;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_last, in_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_msg    <= '0;
      r_live   <= 1'b0;
      r_hold   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      unique case ({w_inc, w_dec})
        2'b10:   r_msg <= r_msg + 1'b1;
        2'b01:   r_msg <= r_msg - 1'b1;
        default: r_msg <= r_msg;
      endcase
      if (w_pop) begin
        r_hold <= 1'b0;
      end else if (out_valid && !out_ready) begin
        r_hold <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_romulus_do_fifo.sv
// tb_romulus_do_fifo: directed scoreboard bench for romulus_do_fifo.
// Pushes queue expected words; pops compare against the queue head.
module tb_romulus_do_fifo;
  localparam int BUSW  = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [BUSW-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            in_ready;
  logic [BUSW-1:0] out_data;
  logic            out_last;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            store_fwd = 1'b0;
  logic [AW:0]     level;
  logic [AW:0]     msg_pending;

  romulus_do_fifo #(.BUSW(BUSW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .store_fwd(store_fwd),
    .level(level), .msg_pending(msg_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [BUSW:0] q[$];
  int m_level = 0;
  int m_msg = 0;
  bit acc;
  bit popd;
  int i;
  bit seen;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic cyc();
    logic [BUSW:0] e;
    #1;
    acc  = in_valid && in_ready;
    popd = out_valid && out_ready;
    if (popd) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL pop_unexpected observed=%0h expected=none", out_data);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_data", out_data, e[BUSW-1:0]);
        chk("out_last", out_last, e[BUSW]);
        m_level--;
        if (e[BUSW]) m_msg--;
      end
    end
    if (acc) begin
      q.push_back({in_last, in_data});
      m_level++;
      if (in_last) m_msg++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("level", level, m_level);
    chk("msg_pending", msg_pending, m_msg);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && m_level != 0; k++) cyc();
    chk("drain_level", level, 0);
    chk("drain_sb", q.size(), 0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_msg", msg_pending, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_in_ready_pre", in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    // 1: cut-through, two words
    store_fwd = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hA0A0A0A0;
    in_last   = 1'b0;
    cyc();
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 32'hA0A0A0A0);
    in_data = 32'hB1B1B1B1;
    in_last = 1'b1;
    cyc();
    chk("t1_data2", out_data, 32'hB1B1B1B1);
    chk("t1_last2", out_last, 1);
    in_valid = 1'b0;
    cyc();
    chk("t1_empty_valid", out_valid, 0);
    chk("t1_empty_data", out_data, 0);
    chk("t1_msg", msg_pending, 0);

    // 2: fill to full, then drain with backlog
    out_ready = 1'b0;
    in_valid  = 1'b1;
    i = 0;
    for (int k = 0; k < 8; k++) begin
      in_data = i;
      in_last = (i == 9);
      cyc();
      if (acc) i++;
    end
    chk("t2_full_ready", in_ready, 0);
    chk("t2_full_level", level, 8);
    in_data = i;
    cyc();
    chk("t2_blocked", acc, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 40 && i < 10; k++) begin
      in_data = i;
      in_last = (i == 9);
      cyc();
      if (acc) i++;
    end
    chk("t2_pushed", i, 10);
    drain();

    // 3: store-and-forward, 3-word message
    store_fwd = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'h3000_0000 + k;
      in_last = (k == 2);
      cyc();
      chk("t3_valid", out_valid, (k == 2));
    end
    chk("t3_msg1", msg_pending, 1);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t3_popped", popd, 1);
    end
    chk("t3_msg0", msg_pending, 0);

    // Hold: presented word survives store_fwd rising
    store_fwd = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hC3C3C3C3;
    in_last   = 1'b0;
    cyc();
    in_valid = 1'b0;
    cyc();
    store_fwd = 1'b1;
    #1;
    chk("hold_valid", out_valid, 1);
    chk("hold_data", out_data, 32'hC3C3C3C3);
    out_ready = 1'b1;
    cyc();
    chk("hold_popped", popd, 1);

    // store_fwd falling takes effect the same cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hD4D4D4D4;
    cyc();
    in_valid = 1'b0;
    chk("sf_gate", out_valid, 0);
    store_fwd = 1'b0;
    #1;
    chk("sf_same_cycle", out_valid, 1);
    drain();

    // 4: store-and-forward, 12-word message
    store_fwd = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    i = 0;
    seen = 1'b0;
    for (int k = 0; k < 100 && i < 12; k++) begin
      in_data = 32'h4000_0000 + i;
      in_last = (i == 11);
      cyc();
      if (acc) i++;
      if (m_level == 8 && !seen) begin
        chk("t4_override", out_valid, 1);
        seen = 1'b1;
      end else if (m_level < 8 && m_msg == 0) begin
        chk("t4_gated", out_valid, 0);
      end
    end
    chk("t4_pushed", i, 12);
    chk("t4_seen_full", seen, 1);
    drain();

    // 5: push and pop together at level 4, across the wrap
    store_fwd = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'hE000_0000 + k;
      in_last = (k == 0);
      cyc();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'hF000_0000 + k;
      in_last = (k != 1);
      cyc();
      chk("t5_both", {acc, popd}, 2'b11);
      chk("t5_level", level, 4);
    end
    chk("t5_msg", msg_pending, 2);
    drain();

    // 6: asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = 32'h6000_0000 + k;
      in_last = (k == 1);
      cyc();
    end
    in_valid = 1'b0;
    chk("t6_level5", level, 5);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_level", level, 0);
    chk("t6_msg", msg_pending, 0);
    chk("t6_ready", in_ready, 0);
    q.delete();
    m_level = 0;
    m_msg   = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_ready_rel", in_ready, 1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h5EED1234;
    in_last   = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("t6_data", out_data, 32'h5EED1234);
    cyc();
    chk("t6_popped", popd, 1);
    chk("t6_sb", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
